xor_session_ctrl: RTL

//   Session sequencer for the serial XOR-encryption datapath. Walks one session:
//   key load -> message load -> encrypt trigger -> ciphertext send.

---
 rtl/xor_session_ctrl.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/xor_session_ctrl.sv
// Session sequencer for the serial XOR-encryption datapath: key load, message load, encrypt, send.
// Optional completed-session counter is enabled by defining XOR_SESSION_COUNT_EN.
module xor_session_ctrl #(
  parameter int KEY_SIZE       = 8,
  parameter int MSG_SIZE       = 64,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       iStart,
  input  logic       iAbort,
  input  logic       iBit_valid,
  input  logic       iCt_done,
  output logic       oKey_flag,
  output logic       oMsg_flag,
  output logic       oEncrypt_go,
  output logic       oBusy,
  output logic       oDone,
  output logic       oError,
  output logic [2:0] oState,
  output logic [7:0] oSession_count
);

  localparam int BW = $clog2(MSG_SIZE) + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [BW-1:0] KEY_LAST = BW'(KEY_SIZE - 1);
  localparam logic [BW-1:0] MSG_LAST = BW'(MSG_SIZE - 1);
  localparam logic [BW-1:0] BIT_ONE  = BW'(1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TO_ONE   = TW'(1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD_KEY = 3'd1,
    S_LOAD_MSG = 3'd2,
    S_ENCRYPT  = 3'd3,
    S_SEND     = 3'd4,
    S_DONE     = 3'd5,
    S_ERROR    = 3'd6
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [BW-1:0]   r_bit_cnt;
  logic [TW-1:0]   r_idle_cnt;

  logic            r_key_flag;
  logic            r_msg_flag;
  logic            r_encrypt_go;
  logic            r_busy;
  logic            r_done;
  logic            r_error;

  logic            w_key_flag_nxt;
  logic            w_msg_flag_nxt;
  logic            w_encrypt_go_nxt;
  logic            w_busy_nxt;
  logic            w_done_nxt;
  logic            w_error_nxt;

  logic            w_waiting;
  logic            w_bit_take;
  logic            w_idle_tick;
  logic            w_timeout;
  logic            w_state_chg;

  // States in which the session is waiting on external activity and may time out
  assign w_waiting   = (r_state == S_LOAD_KEY) || (r_state == S_LOAD_MSG) ||
                       (r_state == S_SEND);
  assign w_bit_take  = iBit_valid &&
                       ((r_state == S_LOAD_KEY) || (r_state == S_LOAD_MSG));
  assign w_idle_tick = w_waiting && !iBit_valid && !iCt_done;
  assign w_timeout   = w_idle_tick && (r_idle_cnt == TO_LAST);
  assign w_state_chg = (w_state_nxt != r_state);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else if (ena) begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (iAbort) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (iStart) w_state_nxt = S_LOAD_KEY;
        end
        S_LOAD_KEY: begin
          if (iBit_valid && (r_bit_cnt == KEY_LAST)) w_state_nxt = S_LOAD_MSG;
          else if (w_timeout)                         w_state_nxt = S_ERROR;
        end
        S_LOAD_MSG: begin
          if (iBit_valid && (r_bit_cnt == MSG_LAST)) w_state_nxt = S_ENCRYPT;
          else if (w_timeout)                         w_state_nxt = S_ERROR;
        end
        S_ENCRYPT: begin
          w_state_nxt = S_SEND;
        end
        S_SEND: begin
          if (iCt_done)       w_state_nxt = S_DONE;
          else if (w_timeout) w_state_nxt = S_ERROR;
        end
        S_DONE: begin
          w_state_nxt = S_IDLE;
        end
        S_ERROR: begin
          w_state_nxt = S_ERROR;
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they are valid on the edge entering a state
  always_comb begin
    w_key_flag_nxt   = 1'b0;
    w_msg_flag_nxt   = 1'b0;
    w_encrypt_go_nxt = 1'b0;
    w_busy_nxt       = 1'b0;
    w_done_nxt       = 1'b0;
    w_error_nxt      = 1'b0;
    case (w_state_nxt)
      S_LOAD_KEY: begin
        w_key_flag_nxt = 1'b1;
        w_busy_nxt     = 1'b1;
      end
      S_LOAD_MSG: begin
        w_msg_flag_nxt = 1'b1;
        w_busy_nxt     = 1'b1;
      end
      S_ENCRYPT: begin
        w_encrypt_go_nxt = 1'b1;
        w_busy_nxt       = 1'b1;
      end
      S_SEND: begin
        w_busy_nxt = 1'b1;
      end
      S_DONE: begin
        w_done_nxt = 1'b1;
        w_busy_nxt = 1'b1;
      end
      S_ERROR: begin
        w_error_nxt = 1'b1;
      end
      default: begin
        w_busy_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key_flag   <= 1'b0;
      r_msg_flag   <= 1'b0;
      r_encrypt_go <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
    end else if (ena) begin
      r_key_flag   <= w_key_flag_nxt;
      r_msg_flag   <= w_msg_flag_nxt;
      r_encrypt_go <= w_encrypt_go_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
      r_error      <= w_error_nxt;
    end
  end

  // Bit counter restarts on every state change, so it never runs past the active target
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_cnt <= '0;
    end else if (ena) begin
      if (w_state_chg)     r_bit_cnt <= '0;
      else if (w_bit_take) r_bit_cnt <= r_bit_cnt + BIT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idle_cnt <= '0;
    end else if (ena) begin
      if (w_state_chg || !w_idle_tick) r_idle_cnt <= '0;
      else                             r_idle_cnt <= r_idle_cnt + TO_ONE;
    end
  end

`ifdef XOR_SESSION_COUNT_EN
  logic [7:0] r_session_cnt;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Survives iAbort; only reset clears the tally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_session_cnt <= 8'h00;
    end else if (ena && (w_state_nxt == S_DONE) && (r_state != S_DONE)) begin
      r_session_cnt <= sat_inc8(r_session_cnt);
    end
  end

  assign oSession_count = r_session_cnt;
`else
  assign oSession_count = 8'h00;
`endif

  assign oKey_flag   = r_key_flag;
  assign oMsg_flag   = r_msg_flag;
  assign oEncrypt_go = r_encrypt_go;
  assign oBusy       = r_busy;
  assign oDone       = r_done;
  assign oError      = r_error;
  assign oState      = r_state;

endmodule
